tilt_step_decoder: RTL and testbench
====================================

Name: tilt_step_decoder

Overview:
- Converts signed accelerometer tilt samples into the level-style x/y increment/decrement commands consumed by the ball position block.
- Each axis runs a debounced hysteresis state machine, so the commands cannot chatter or assert in both directions at once.
- Sits between the accelerometer sample interface (valid/ready) and the ball position block, which samples the command levels on its own update tick.

Parameters:
- CLK_FREQUENCY_HZ, 100000000, input clock frequency.
- SAMPLE_WIDTH, 8, two's-complement width of each axis sample.
- ENTER_TH, 24, magnitude at or above which a sample counts as tilted (1..2^(SAMPLE_WIDTH-1)-1).
- EXIT_TH, 12, magnitude below which a sample counts as centred; must be < ENTER_TH.
- DEBOUNCE_SAMPLES, 3, consecutive tilted samples needed to assert a command (1..15).
- STALE_TIMEOUT_MS, 50, sample-loss timeout (used only with the optional feature).
- SIMULATE, 0, 1 = use SIMULATE_TIMEOUT_CNT as the timeout count.
- SIMULATE_TIMEOUT_CNT, 20, timeout in cycles when SIMULATE=1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- accel_x  input  SAMPLE_WIDTH  signed x tilt sample.
- accel_y  input  SAMPLE_WIDTH  signed y tilt sample.
- accel_valid  input  1  sample pair present.
- accel_ready  output  1  block can accept a sample.
- x_increment  output  1  command level, +x tilt.
- x_decrement  output  1  command level, -x tilt.
- y_increment  output  1  command level, +y tilt.
- y_decrement  output  1  command level, -y tilt.
- stale  output  1  no sample received within the timeout.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, accel_ready 0, both axis FSMs in IDLE, debounce counters 0, timeout counter 0. Reset mid-debounce discards partial counts.
- accel_ready is registered. It is 1 from the first cycle after reset, and 0 for exactly one cycle after each accept (single-entry input register). Accept = accel_valid & accel_ready.
- Pipeline:
  - Cycle N: accept; the sample pair is registered.
  - Cycle N+1: classify.
  - Cycle N+2: FSM state and command outputs update.
  - Total latency is 2 cycles from accept to output change.
- Classification per axis, with s signed and comparisons done in SAMPLE_WIDTH+1 bits so that -2^(SAMPLE_WIDTH-1) is handled correctly:
  - POS if s >= ENTER_TH.
  - NEG if s <= -ENTER_TH.
  - CTR if |s| < EXIT_TH.
  - HOLD otherwise.
- Per-axis FSM states: IDLE, PEND_POS, POS, PEND_NEG, NEG.
  - IDLE:
    - POS -> PEND_POS, cnt=1.
    - NEG -> PEND_NEG, cnt=1.
    - else stay.
  - PEND_POS:
    - POS -> cnt+1.
    - NEG -> PEND_NEG, cnt=1.
    - CTR or HOLD -> IDLE, cnt=0.
  - PEND_NEG: mirror of PEND_POS.
  - When cnt reaches DEBOUNCE_SAMPLES, the FSM enters POS/NEG in the same update. With DEBOUNCE_SAMPLES=1, the first POS sample goes IDLE -> POS directly.
  - POS:
    - POS or HOLD -> stay.
    - CTR -> IDLE.
    - NEG -> PEND_NEG, cnt=1 (increment drops immediately).
  - NEG: mirror of POS.
- Outputs are registered decodes of the FSM state:
  - *_increment = (state==POS); *_decrement = (state==NEG).
  - Increment and decrement are never both 1 on the same axis.
- The x and y FSMs are fully independent. Simultaneous commands on both axes are legal.
- Counters saturate. No wrap-around on cnt.

Optional Feature:
- TILT_STALE_TIMEOUT_EN defined:
  - A 32-bit counter clears on each accept and increments otherwise.
  - Top count = SIMULATE ? SIMULATE_TIMEOUT_CNT : CLK_FREQUENCY_HZ/1000*STALE_TIMEOUT_MS - 1.
  - On reaching top: both FSMs forced to IDLE, cnt cleared, all four commands 0 on the next cycle, stale=1, counter holds.
  - stale clears in the cycle after the next accept. That sample is classified normally, from IDLE.
- Not defined: no timeout counter; stale tied to 0; commands persist indefinitely without samples.

Test Plan:
- Reset asserted 3 cycles with accel_valid=1 -> all commands 0, stale 0, accel_ready 0 during reset, 1 on the first cycle after release, 0 the cycle after each accept.
- Three x=+30, y=0 samples -> x_increment rises 2 cycles after the third accept. Two x=+30 then one x=0 -> x_increment stays 0 and the FSM returns to IDLE.
- Hysteresis, from POS: x=+15 -> x_increment held; then x=+11 -> x_increment falls 2 cycles after that accept.
- Reversal, from POS: x=-40 -> x_increment falls 2 cycles after the accept; x_decrement rises after the third -40 sample; both commands never 1 together.
- Boundaries:
  - Three y=-128 with x=+24 -> y_decrement=1 and x_increment=1 together.
  - Three x=+23 from IDLE -> no command (HOLD).
  - Reset asserted after two x=+30 samples, then one more +30 -> no command.
- With TILT_STALE_TIMEOUT_EN, SIMULATE=1, SIMULATE_TIMEOUT_CNT=20: from x POS, no valid for 21 cycles -> commands 0, stale=1; next x=+30 accept -> stale 0, x_increment 0 until two more +30 samples.

Source files
------------

// File: rtl/tilt_step_decoder.sv
// Debounced, hysteretic tilt-to-command decoder for the ball position block.
// Optional sample-loss timeout is enabled by defining TILT_STALE_TIMEOUT_EN.
module tilt_step_decoder #(
  parameter int CLK_FREQUENCY_HZ     = 100000000,
  parameter int SAMPLE_WIDTH         = 8,
  parameter int ENTER_TH             = 24,
  parameter int EXIT_TH              = 12,
  parameter int DEBOUNCE_SAMPLES     = 3,
  parameter int STALE_TIMEOUT_MS     = 50,
  parameter int SIMULATE             = 0,
  parameter int SIMULATE_TIMEOUT_CNT = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] accel_x,
  input  logic [SAMPLE_WIDTH-1:0] accel_y,
  input  logic                    accel_valid,
  output logic                    accel_ready,
  output logic                    x_increment,
  output logic                    x_decrement,
  output logic                    y_increment,
  output logic                    y_decrement,
  output logic                    stale
);

  typedef enum logic [1:0] {
    CLS_HOLD,
    CLS_CTR,
    CLS_POS,
    CLS_NEG
  } cls_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND_POS,
    ST_POS,
    ST_PEND_NEG,
    ST_NEG
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [3:0] cnt;
  } axis_t;

  localparam int W = SAMPLE_WIDTH;

  // Thresholds live in W+1 bits so that the most negative sample has a magnitude.
  localparam logic signed [W:0] ENTER_P = (W+1)'(ENTER_TH);
  localparam logic signed [W:0] ENTER_N = -ENTER_P;
  localparam logic signed [W:0] EXIT_P  = (W+1)'(EXIT_TH);
  localparam logic signed [W:0] EXIT_N  = -EXIT_P;
  localparam logic [3:0]        DEB_CNT = 4'(DEBOUNCE_SAMPLES);
  localparam axis_t             AXIS_IDLE = '{state: ST_IDLE, cnt: 4'd0};

  if (ENTER_TH < 1 || ENTER_TH > (2 ** (SAMPLE_WIDTH - 1)) - 1) begin : g_bad_enter
    $error("tilt_step_decoder: ENTER_TH out of range");
  end
  if (EXIT_TH >= ENTER_TH) begin : g_bad_exit
    $error("tilt_step_decoder: EXIT_TH must be below ENTER_TH");
  end
  if (DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 15) begin : g_bad_debounce
    $error("tilt_step_decoder: DEBOUNCE_SAMPLES out of range");
  end
  if (SIMULATE != 0 && SIMULATE_TIMEOUT_CNT < 1) begin : g_bad_sim_timeout
    $error("tilt_step_decoder: SIMULATE_TIMEOUT_CNT must be positive");
  end
  if (SIMULATE == 0 && (CLK_FREQUENCY_HZ / 1000) * STALE_TIMEOUT_MS < 1) begin : g_bad_timeout
    $error("tilt_step_decoder: stale timeout evaluates to zero cycles");
  end

  function automatic cls_t classify(input logic [W-1:0] s);
    logic signed [W:0] v;
    v = $signed({s[W-1], s});
    if (v >= ENTER_P)                   return CLS_POS;
    else if (v <= ENTER_N)              return CLS_NEG;
    else if (v > EXIT_N && v < EXIT_P)  return CLS_CTR;
    else                                return CLS_HOLD;
  endfunction

  // First tilted sample in a direction; commits at once when one sample suffices.
  function automatic axis_t begin_pend(input logic neg);
    axis_t r;
    r.cnt = 4'd1;
    if (neg) r.state = ST_PEND_NEG;
    else     r.state = ST_PEND_POS;
    if (DEB_CNT <= 4'd1) begin
      r.cnt = 4'd0;
      if (neg) r.state = ST_NEG;
      else     r.state = ST_POS;
    end
    return r;
  endfunction

  function automatic axis_t advance(input axis_t cur, input logic neg);
    axis_t      r;
    logic [3:0] n;
    n = (cur.cnt == 4'hF) ? 4'hF : cur.cnt + 4'd1;
    if (n >= DEB_CNT) begin
      r.cnt = 4'd0;
      if (neg) r.state = ST_NEG;
      else     r.state = ST_POS;
    end else begin
      r.cnt   = n;
      r.state = cur.state;
    end
    return r;
  endfunction

  function automatic axis_t step(input axis_t cur, input cls_t cls);
    axis_t r;
    r = cur;
    unique case (cur.state)
      ST_IDLE: begin
        if (cls == CLS_POS)      r = begin_pend(1'b0);
        else if (cls == CLS_NEG) r = begin_pend(1'b1);
      end
      ST_PEND_POS: begin
        if (cls == CLS_POS)      r = advance(cur, 1'b0);
        else if (cls == CLS_NEG) r = begin_pend(1'b1);
        else                     r = AXIS_IDLE;
      end
      ST_PEND_NEG: begin
        if (cls == CLS_NEG)      r = advance(cur, 1'b1);
        else if (cls == CLS_POS) r = begin_pend(1'b0);
        else                     r = AXIS_IDLE;
      end
      ST_POS: begin
        if (cls == CLS_CTR)      r = AXIS_IDLE;
        else if (cls == CLS_NEG) r = begin_pend(1'b1);
      end
      ST_NEG: begin
        if (cls == CLS_CTR)      r = AXIS_IDLE;
        else if (cls == CLS_POS) r = begin_pend(1'b0);
      end
      default: r = AXIS_IDLE;
    endcase
    return r;
  endfunction

  // Handshake: a sample pair transfers on a rising edge where accel_valid and
  // accel_ready are both 1; accel_ready then drops for exactly one cycle while
  // the single input register hands the pair to the classifier.
  logic         accept;
  logic [W-1:0] smp_x;
  logic [W-1:0] smp_y;
  logic         smp_vld;
  cls_t         cls_x;
  cls_t         cls_y;
  logic         cls_vld;
  axis_t        x_axis;
  axis_t        y_axis;
  axis_t        x_next;
  axis_t        y_next;
  logic         force_idle;

  assign accept = accel_valid & accel_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      accel_ready <= 1'b0;
      smp_x       <= '0;
      smp_y       <= '0;
      smp_vld     <= 1'b0;
      cls_x       <= CLS_HOLD;
      cls_y       <= CLS_HOLD;
      cls_vld     <= 1'b0;
    end else begin
      accel_ready <= ~accept;
      smp_vld     <= accept;
      if (accept) begin
        smp_x <= accel_x;
        smp_y <= accel_y;
      end
      cls_vld <= smp_vld;
      if (smp_vld) begin
        cls_x <= classify(smp_x);
        cls_y <= classify(smp_y);
      end
    end
  end

  always_comb begin
    x_next = step(x_axis, cls_x);
    y_next = step(y_axis, cls_y);
  end

  // Both axis FSMs with their registered command decodes.
  always_ff @(posedge clk) begin
    if (reset || force_idle) begin
      x_axis      <= AXIS_IDLE;
      y_axis      <= AXIS_IDLE;
      x_increment <= 1'b0;
      x_decrement <= 1'b0;
      y_increment <= 1'b0;
      y_decrement <= 1'b0;
    end else if (cls_vld) begin
      x_axis      <= x_next;
      y_axis      <= y_next;
      x_increment <= (x_next.state == ST_POS);
      x_decrement <= (x_next.state == ST_NEG);
      y_increment <= (y_next.state == ST_POS);
      y_decrement <= (y_next.state == ST_NEG);
    end
  end

`ifdef TILT_STALE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_TOP = (SIMULATE != 0)
    ? 32'(SIMULATE_TIMEOUT_CNT)
    : 32'((CLK_FREQUENCY_HZ / 1000) * STALE_TIMEOUT_MS - 1);

  logic [31:0] tmo_cnt;
  logic        stale_q;

  // The counter parks at the top so the FSMs stay idle until a sample returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      stale_q <= 1'b0;
    end else if (accept) begin
      tmo_cnt <= '0;
      stale_q <= 1'b0;
    end else begin
      if (tmo_cnt != TIMEOUT_TOP) tmo_cnt <= tmo_cnt + 32'd1;
      if (tmo_cnt == TIMEOUT_TOP) stale_q <= 1'b1;
    end
  end

  assign force_idle = ~accept & (tmo_cnt == TIMEOUT_TOP);
  assign stale      = stale_q;
`else
  assign force_idle = 1'b0;
  assign stale      = 1'b0;
`endif

endmodule

// File: tb/tb_tilt_step_decoder.sv
// Directed bench for tilt_step_decoder: reset, debounce, hysteresis, reversal,
// thresholds, back-to-back handshakes and the sample-loss behaviour.
module tb_tilt_step_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] accel_x;
  logic [7:0] accel_y;
  logic       accel_valid;
  logic       accel_ready;
  logic       x_increment;
  logic       x_decrement;
  logic       y_increment;
  logic       y_decrement;
  logic       stale;
  logic [3:0] cmds;

  int compared   = 0;
  int mismatched = 0;

  tilt_step_decoder #(
    .SIMULATE            (1),
    .SIMULATE_TIMEOUT_CNT(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_valid(accel_valid),
    .accel_ready(accel_ready),
    .x_increment(x_increment),
    .x_decrement(x_decrement),
    .y_increment(y_increment),
    .y_decrement(y_decrement),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  assign cmds = {x_increment, x_decrement, y_increment, y_decrement};

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send(input int x, input int y);
    int n = 0;
    while (accel_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (accel_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL send_ready_timeout: accel_ready=%b expected 1", accel_ready);
    end
    accel_x     = x[7:0];
    accel_y     = y[7:0];
    accel_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accel_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    accel_valid = 1'b1;
    accel_x     = 8'd0;
    accel_y     = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (accel_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_ready: accel_ready=%b expected 0", accel_ready);
      end
      compared++;
      if ({cmds, stale} !== 5'b0) begin
        mismatched++;
        $display("FAIL reset_outputs: cmds/stale=%b expected 00000", {cmds, stale});
      end
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (accel_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL release_ready: accel_ready=%b expected 1", accel_ready);
    end
    @(negedge clk);
    compared++;
    if (accel_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_after_accept: accel_ready=%b expected 0", accel_ready);
    end
    accel_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (accel_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_recovers: accel_ready=%b expected 1", accel_ready);
    end
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL post_reset_cmds: cmds=%b expected 0000", cmds);
    end
  endtask

  task automatic test_debounce;
    send(30, 0);
    send(30, 0);
    send(30, 0);
    compared++;
    if (x_increment !== 1'b0) begin
      mismatched++;
      $display("FAIL debounce_early0: x_increment=%b expected 0", x_increment);
    end
    @(negedge clk);
    compared++;
    if (x_increment !== 1'b0) begin
      mismatched++;
      $display("FAIL debounce_early1: x_increment=%b expected 0", x_increment);
    end
    @(negedge clk);
    compared++;
    if (cmds !== 4'b1000) begin
      mismatched++;
      $display("FAIL debounce_rise: cmds=%b expected 1000", cmds);
    end
    send(0, 0);
    wait_cycles(2);
    send(30, 0);
    send(30, 0);
    send(0, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL debounce_abort: cmds=%b expected 0000", cmds);
    end
    // Only a fresh count from IDLE keeps two more samples below the threshold.
    send(30, 0);
    send(30, 0);
    wait_cycles(2);
    compared++;
    if (x_increment !== 1'b0) begin
      mismatched++;
      $display("FAIL debounce_restart: x_increment=%b expected 0", x_increment);
    end
    send(30, 0);
    wait_cycles(2);
    compared++;
    if (x_increment !== 1'b1) begin
      mismatched++;
      $display("FAIL debounce_restart_rise: x_increment=%b expected 1", x_increment);
    end
    send(0, 0);
    wait_cycles(2);
  endtask

  task automatic test_hysteresis;
    for (int i = 0; i < 3; i++) send(30, 0);
    wait_cycles(2);
    send(15, 0);
    wait_cycles(2);
    compared++;
    if (x_increment !== 1'b1) begin
      mismatched++;
      $display("FAIL hyst_hold15: x_increment=%b expected 1", x_increment);
    end
    send(12, 0);
    wait_cycles(2);
    compared++;
    if (x_increment !== 1'b1) begin
      mismatched++;
      $display("FAIL hyst_hold12: x_increment=%b expected 1", x_increment);
    end
    send(11, 0);
    @(negedge clk);
    compared++;
    if (x_increment !== 1'b1) begin
      mismatched++;
      $display("FAIL hyst_fall_early: x_increment=%b expected 1", x_increment);
    end
    @(negedge clk);
    compared++;
    if (x_increment !== 1'b0) begin
      mismatched++;
      $display("FAIL hyst_fall: x_increment=%b expected 0", x_increment);
    end
  endtask

  task automatic test_reversal;
    for (int i = 0; i < 3; i++) send(30, 0);
    wait_cycles(2);
    send(-40, 0);
    @(negedge clk);
    compared++;
    if (cmds !== 4'b1000) begin
      mismatched++;
      $display("FAIL rev_early: cmds=%b expected 1000", cmds);
    end
    @(negedge clk);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL rev_drop: cmds=%b expected 0000", cmds);
    end
    send(-40, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL rev_pend: cmds=%b expected 0000", cmds);
    end
    send(-40, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0100) begin
      mismatched++;
      $display("FAIL rev_dec: cmds=%b expected 0100", cmds);
    end
    send(0, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL rev_centre: cmds=%b expected 0000", cmds);
    end
  endtask

  task automatic test_boundaries;
    for (int i = 0; i < 3; i++) send(24, -128);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b1001) begin
      mismatched++;
      $display("FAIL bound_both_axes: cmds=%b expected 1001", cmds);
    end
    send(0, 0);
    wait_cycles(2);
    for (int i = 0; i < 3; i++) send(23, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL bound_23_hold: cmds=%b expected 0000", cmds);
    end
    for (int i = 0; i < 3; i++) send(-24, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0100) begin
      mismatched++;
      $display("FAIL bound_neg24: cmds=%b expected 0100", cmds);
    end
    send(0, 0);
    wait_cycles(2);
    send(30, 0);
    send(30, 0);
    wait_cycles(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(30, 0);
    wait_cycles(2);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL bound_reset_discard: cmds=%b expected 0000", cmds);
    end
    send(0, 0);
    wait_cycles(2);
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_ready;
    exp_ready   = 5'b01010;
    accel_x     = 8'd30;
    accel_y     = 8'd30;
    accel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if (accel_ready !== exp_ready[4-i]) begin
        mismatched++;
        $display("FAIL b2b_ready[%0d]: accel_ready=%b expected %b", i, accel_ready, exp_ready[4-i]);
      end
    end
    accel_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (cmds !== 4'b0000) begin
      mismatched++;
      $display("FAIL b2b_early: cmds=%b expected 0000", cmds);
    end
    @(negedge clk);
    compared++;
    if (cmds !== 4'b1010) begin
      mismatched++;
      $display("FAIL b2b_rise: cmds=%b expected 1010", cmds);
    end
  endtask

`ifdef TILT_STALE_TIMEOUT_EN
  task automatic test_stale;
    // Commands already high; last accept happened just before this point.
    send(30, 30);
    wait_cycles(20);
    compared++;
    if ({cmds, stale} !== 5'b10100) begin
      mismatched++;
      $display("FAIL stale_before: cmds/stale=%b expected 10100", {cmds, stale});
    end
    @(negedge clk);
    compared++;
    if ({cmds, stale} !== 5'b00001) begin
      mismatched++;
      $display("FAIL stale_hit: cmds/stale=%b expected 00001", {cmds, stale});
    end
    send(30, 0);
    compared++;
    if (stale !== 1'b0) begin
      mismatched++;
      $display("FAIL stale_clear: stale=%b expected 0", stale);
    end
    wait_cycles(2);
    send(30, 0);
    wait_cycles(2);
    compared++;
    if (x_increment !== 1'b0) begin
      mismatched++;
      $display("FAIL stale_restart: x_increment=%b expected 0", x_increment);
    end
    send(30, 0);
    wait_cycles(2);
    compared++;
    if (x_increment !== 1'b1) begin
      mismatched++;
      $display("FAIL stale_recover: x_increment=%b expected 1", x_increment);
    end
  endtask
`else
  task automatic test_stale;
    wait_cycles(40);
    compared++;
    if ({cmds, stale} !== 5'b10100) begin
      mismatched++;
      $display("FAIL persist: cmds/stale=%b expected 10100", {cmds, stale});
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    accel_valid = 1'b0;
    accel_x     = 8'd0;
    accel_y     = 8'd0;
    test_reset();
    test_debounce();
    test_hysteresis();
    test_reversal();
    test_boundaries();
    test_back_to_back();
    test_stale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
